// File: rtl/aes_cipher_iter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_cipher_iter_pkg
// Brief    : Shared AES types, constants and GF(2^8) helpers for the
//            iterative cipher core and its round stage.
// Revision : 1.0 - initial release
// ============================================================================
package aes_cipher_iter_pkg;

    localparam int DATA_WIDTH = 128;
    localparam int RK_IDX_W   = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } aes_iter_state_e;

    localparam logic [7:0] c_sbox [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Number of rounds for a key of nk 32-bit words.
    function automatic int nr_of(input int nk);
        return nk + 6;
    endfunction

    // Multiply by x in GF(2^8) with the AES reduction polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by x+1 in GF(2^8).
    function automatic logic [7:0] mul3(input logic [7:0] b);
        return xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return c_sbox[b];
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_cipher_iter_if.sv
`default_nettype none
// ============================================================================
// Module   : aes_cipher_iter_if
// Brief    : Block datapath (valid/ready in and out), round-key store port
//            and status of the iterative AES core. The core is the slave.
// Revision : 1.0 - initial release
// ============================================================================
interface aes_cipher_iter_if #(
    parameter int ROUNDS_PER_CYCLE = 1
);
    logic                                                         in_valid;
    logic                                                         in_ready;
    logic [aes_cipher_iter_pkg::DATA_WIDTH-1:0]                   in_data;
    logic [aes_cipher_iter_pkg::RK_IDX_W-1:0]                     rk_idx;
    logic [aes_cipher_iter_pkg::DATA_WIDTH*ROUNDS_PER_CYCLE-1:0]  rk_data;
    logic                                                         out_valid;
    logic                                                         out_ready;
    logic [aes_cipher_iter_pkg::DATA_WIDTH-1:0]                   out_data;
    logic                                                         busy;

    modport master (
        output in_valid, in_data, out_ready, rk_data,
        input  in_ready, rk_idx, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready, rk_data,
        output in_ready, rk_idx, out_valid, out_data, busy
    );
endinterface
`default_nettype wire

// File: rtl/aes_cipher_iter_round_comb.sv
`default_nettype none
// ============================================================================
// Module   : aes_round_comb
// Brief    : One combinational AES encryption round: SubBytes, ShiftRows,
//            MixColumns (skipped when is_last) and AddRoundKey.
//            Byte i of a block sits at [127-8i -: 8]; byte i = row + 4*col.
// Revision : 1.0 - initial release
// ============================================================================
module aes_round_comb
    import aes_cipher_iter_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] i_state,
    input  logic [DATA_WIDTH-1:0] i_key,
    input  logic                  is_last,
    output logic [DATA_WIDTH-1:0] o_state
);
    logic [7:0] w_sub [16];
    logic [7:0] w_shf [16];
    logic [7:0] w_mix [16];

    // SubBytes on every byte of the incoming state.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            w_sub[i] = sbox(i_state[127-8*i -: 8]);
        end
    end

    // ShiftRows: row r rotates left by r columns.
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_shf[4*c+r] = w_sub[4*((c+r)%4)+r];
            end
        end
    end

    // MixColumns on each column.
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            w_mix[4*c+0] = xtime(w_shf[4*c]) ^ mul3(w_shf[4*c+1]) ^ w_shf[4*c+2] ^ w_shf[4*c+3];
            w_mix[4*c+1] = w_shf[4*c] ^ xtime(w_shf[4*c+1]) ^ mul3(w_shf[4*c+2]) ^ w_shf[4*c+3];
            w_mix[4*c+2] = w_shf[4*c] ^ w_shf[4*c+1] ^ xtime(w_shf[4*c+2]) ^ mul3(w_shf[4*c+3]);
            w_mix[4*c+3] = mul3(w_shf[4*c]) ^ w_shf[4*c+1] ^ w_shf[4*c+2] ^ xtime(w_shf[4*c+3]);
        end
    end

    // AddRoundKey; the final round bypasses MixColumns.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            o_state[127-8*i -: 8] = (is_last ? w_shf[i] : w_mix[i]) ^ i_key[127-8*i -: 8];
        end
    end
endmodule
`default_nettype wire

// File: rtl/aes_cipher_iter.sv
`default_nettype none
// ============================================================================
// Module   : aes_cipher_iter
// Brief    : Iterative AES encryption core. Whitens an accepted block with
//            key 0, then applies ROUNDS_PER_CYCLE rounds per clock, fetching
//            round keys from an external store through rk_idx.
// Config   : AES_CIPHER_ZEROIZE_EN - clear the state register on the output
//            handshake so no ciphertext lingers after delivery.
// Revision : 1.0 - initial release
// ============================================================================
module aes_cipher_iter
    import aes_cipher_iter_pkg::*;
#(
    parameter int NK               = 4,
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    aes_cipher_iter_if.slave bus
);
    localparam int                  c_nr       = nr_of(NK);
    localparam int                  c_rpc      = ROUNDS_PER_CYCLE;
    localparam logic [RK_IDX_W-1:0] c_nr_idx   = RK_IDX_W'(c_nr);
    localparam logic [RK_IDX_W-1:0] c_rpc_idx  = RK_IDX_W'(c_rpc);
    // Round counter value on the cycle that applies round NR.
    localparam logic [RK_IDX_W-1:0] c_last_rnd = RK_IDX_W'(c_nr - c_rpc + 1);

    if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
        $error("aes_cipher_iter: NK must be 4, 6 or 8");
    end
    if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2)) begin : g_bad_rpc
        $error("aes_cipher_iter: ROUNDS_PER_CYCLE must be 1 or 2");
    end

    aes_iter_state_e       r_fsm;
    logic [DATA_WIDTH-1:0] r_state;
    logic [RK_IDX_W-1:0]   r_rnd;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic                  r_busy;

    logic [DATA_WIDTH-1:0] w_key0;
    logic [DATA_WIDTH-1:0] w_round0;
    logic [DATA_WIDTH-1:0] w_next;
    logic                  w_last0;
    logic                  w_last_cycle;

    // The most significant key slice is always key rk_idx.
    assign w_key0       = bus.rk_data[DATA_WIDTH*c_rpc-1 -: DATA_WIDTH];
    assign w_last0      = (r_rnd == c_nr_idx);
    assign w_last_cycle = (r_rnd == c_last_rnd);

    aes_round_comb u_round0 (
        .i_state (r_state),
        .i_key   (w_key0),
        .is_last (w_last0),
        .o_state (w_round0)
    );

    if (c_rpc == 2) begin : g_two_rounds
        logic [DATA_WIDTH-1:0] w_round1;
        logic                  w_last1;

        assign w_last1 = ((r_rnd + RK_IDX_W'(1)) == c_nr_idx);

        aes_round_comb u_round1 (
            .i_state (w_round0),
            .i_key   (bus.rk_data[DATA_WIDTH-1:0]),
            .is_last (w_last1),
            .o_state (w_round1)
        );

        assign w_next = w_round1;
    end else begin : g_one_round
        assign w_next = w_round0;
    end

    // Control FSM with registered handshake outputs; r_rnd doubles as rk_idx.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm       <= S_IDLE;
            r_state     <= '0;
            r_rnd       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    if (bus.in_valid && r_in_ready) begin
                        r_state    <= bus.in_data ^ w_key0;
                        r_rnd      <= RK_IDX_W'(1);
                        r_fsm      <= S_RUN;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_state <= w_next;
                    if (w_last_cycle) begin
                        r_fsm       <= S_DONE;
                        r_rnd       <= '0;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_rnd <= r_rnd + c_rpc_idx;
                    end
                end
                S_DONE: begin
                    // in_ready rises only after the handshake, so a block
                    // offered in the same cycle is taken one clock later.
                    if (bus.out_ready) begin
                        r_fsm       <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
`ifdef AES_CIPHER_ZEROIZE_EN
                        r_state     <= '0;
`endif
                    end
                end
                default: begin
                    r_fsm <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_state;
    assign bus.busy      = r_busy;
    assign bus.rk_idx    = r_rnd;
endmodule
`default_nettype wire

// File: tb/tb_aes_cipher_iter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_aes_cipher_iter
// Brief    : Bench for aes_cipher_iter. Six cores cover NK 4/6/8 with one and
//            two rounds per clock; round keys come from a local key-expansion
//            model, expected ciphertexts from a local cipher model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_cipher_iter;
    localparam int c_ndut = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         tb_in_valid  [c_ndut];
    logic [127:0] tb_in_data   [c_ndut];
    logic         tb_out_ready [c_ndut];
    logic         tb_in_ready  [c_ndut];
    logic         tb_out_valid [c_ndut];
    logic [127:0] tb_out_data  [c_ndut];
    logic [3:0]   tb_rk_idx    [c_ndut];
    logic         tb_busy      [c_ndut];
    logic [127:0] rk_tab       [c_ndut][16];

    for (genvar g = 0; g < c_ndut; g++) begin : g_dut
        localparam int c_nk  = 4 + 2 * (g % 3);
        localparam int c_rpc = 1 + g / 3;

        aes_cipher_iter_if #(.ROUNDS_PER_CYCLE(c_rpc)) u_if ();

        assign u_if.in_valid  = tb_in_valid[g];
        assign u_if.in_data   = tb_in_data[g];
        assign u_if.out_ready = tb_out_ready[g];
        assign tb_in_ready[g]  = u_if.in_ready;
        assign tb_out_valid[g] = u_if.out_valid;
        assign tb_out_data[g]  = u_if.out_data;
        assign tb_rk_idx[g]    = u_if.rk_idx;
        assign tb_busy[g]      = u_if.busy;

        if (c_rpc == 1) begin : g_rk1
            assign u_if.rk_data = rk_tab[g][u_if.rk_idx];
        end else begin : g_rk2
            assign u_if.rk_data = {rk_tab[g][u_if.rk_idx], rk_tab[g][u_if.rk_idx + 4'd1]};
        end

        aes_cipher_iter #(.NK(c_nk), .ROUNDS_PER_CYCLE(c_rpc)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (u_if.slave)
        );
    end

    int total = 0;
    int bad   = 0;
    int rk_viol = 0;
    logic [127:0] exp_q [$];
    logic [7:0]   sb [256];

    function automatic int nr_g(input int g);
        return 10 + 2 * (g % 3);
    endfunction

    function automatic int rpc_g(input int g);
        return 1 + g / 3;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return 8'((x << n) | (x >> (8 - n)));
    endfunction

    // S-box from the multiplicative inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            end
            sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    task automatic expand(input int g, input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rcon = 8'h01;
        int nk = 4 + 2 * (g % 3);
        int nr = nk + 6;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 16; r++) begin
            rk_tab[g][r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
        end
    endtask

    function automatic logic [127:0] ref_enc(input int g, input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] k;
        logic [127:0] res;
        int nr = 10 + 2 * (g % 3);
        k = rk_tab[g][0];
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ k[127-8*i -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++) s[4*c+w] = t[4*((c+w)%4)+w];
            if (r != nr) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            k = rk_tab[g][r];
            for (int i = 0; i < 16; i++) s[i] ^= k[127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- driver / monitor helpers ----------------
    // Offer pt, wait for acceptance, push its expected ciphertext.
    task automatic send(input int g, input logic [127:0] pt, input logic [127:0] exp);
        int n = 0;
        tb_in_data[g]  = pt;
        tb_in_valid[g] = 1'b1;
        @(negedge clk);
        while (!tb_in_ready[g] && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("accept", 128'(tb_in_ready[g]), 128'(1));
        @(posedge clk);
        #1;
        tb_in_valid[g] = 1'b0;
        exp_q.push_back(exp);
    endtask

    // Clocks from the accept edge until out_valid is seen.
    task automatic wait_out(input int g, output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!tb_out_valid[g] && lat < 60);
    endtask

    task automatic pop_chk(input string tag, input logic [127:0] obs);
        logic [127:0] e = 128'hx;
        chk({tag, "_sb_nonempty"}, 128'(exp_q.size() > 0), 128'(1));
        if (exp_q.size() > 0) e = exp_q.pop_front();
        chk(tag, obs, e);
    endtask

    // Compare the presented ciphertext and complete the output handshake.
    task automatic recv(input int g, input string tag);
        pop_chk(tag, tb_out_data[g]);
        tb_out_ready[g] = 1'b1;
        @(posedge clk);
        #1;
        tb_out_ready[g] = 1'b0;
    endtask

    // rk_idx must never address a key beyond round NR.
    always @(negedge clk) begin
        for (int g = 0; g < c_ndut; g++) begin
            if (rst === 1'b0 && tb_rk_idx[g] > 4'(nr_g(g))) rk_viol++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    localparam logic [255:0] c_key_fips = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] c_key_seq  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] c_pt_seq   = 128'h00112233445566778899aabbccddeeff;

    initial begin
        logic [127:0] kat [3];
        logic [127:0] ct;
        logic [127:0] held;
        int lat;
        int errs;

        kat[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        kat[1] = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
        kat[2] = 128'h8ea2b7ca516745bfeafc49904b496089;

        rst = 1'b1;
        for (int g = 0; g < c_ndut; g++) begin
            tb_in_valid[g]  = 1'b0;
            tb_in_data[g]   = '0;
            tb_out_ready[g] = 1'b0;
        end
        build_sbox();
        for (int g = 0; g < c_ndut; g++) expand(g, c_key_seq);
        expand(0, c_key_fips);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state of every core.
        @(negedge clk);
        for (int g = 0; g < c_ndut; g++) begin
            chk($sformatf("rst_in_ready%0d", g), 128'(tb_in_ready[g]), 128'(1));
            chk($sformatf("rst_out_valid%0d", g), 128'(tb_out_valid[g]), 128'(0));
            chk($sformatf("rst_busy%0d", g), 128'(tb_busy[g]), 128'(0));
            chk($sformatf("rst_rk_idx%0d", g), 128'(tb_rk_idx[g]), 128'(0));
        end
        chk("rst_out_data", tb_out_data[0], 128'h0);

        // FIPS-197 appendix B vector, then post-handshake out_data.
        chk("model_fips", ref_enc(0, 128'h3243f6a8885a308d313198a2e0370734),
            128'h3925841d02dc09fbdc118597196a0b32);
        @(posedge clk);
        #1;
        send(0, 128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32);
        wait_out(0, lat);
        chk("fips_latency", 128'(lat), 128'(10));
        ct = tb_out_data[0];
        recv(0, "fips_ct");
        chk("post_hs_out_valid", 128'(tb_out_valid[0]), 128'(0));
        chk("post_hs_in_ready", 128'(tb_in_ready[0]), 128'(1));
`ifdef AES_CIPHER_ZEROIZE_EN
        chk("post_hs_out_data", tb_out_data[0], 128'h0);
`else
        chk("post_hs_out_data", tb_out_data[0], ct);
`endif

        // Known answers for every NK and rounds-per-cycle combination.
        expand(0, c_key_seq);
        for (int g = 0; g < c_ndut; g++) begin
            chk($sformatf("model_kat%0d", g), ref_enc(g, c_pt_seq), kat[g%3]);
            send(g, c_pt_seq, kat[g%3]);
            wait_out(g, lat);
            chk($sformatf("kat_latency%0d", g), 128'(lat), 128'(nr_g(g) / rpc_g(g)));
            recv(g, $sformatf("kat_ct%0d", g));
        end

        // Back-pressure: 20 held clocks, in_valid high throughout.
        send(0, 128'hffeeddccbbaa99887766554433221100, ref_enc(0, 128'hffeeddccbbaa99887766554433221100));
        wait_out(0, lat);
        chk("bp_latency", 128'(lat), 128'(10));
        held = tb_out_data[0];
        tb_in_data[0]  = 128'h0123456789abcdef0123456789abcdef;
        tb_in_valid[0] = 1'b1;
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tb_out_valid[0] !== 1'b1 || tb_out_data[0] !== held || tb_in_ready[0] !== 1'b0) errs++;
        end
        chk("bp_hold", 128'(errs), 128'(0));
        pop_chk("bp_ct", tb_out_data[0]);
        tb_out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        tb_out_ready[0] = 1'b0;
        chk("bp_no_accept_on_hs", 128'(tb_busy[0]), 128'(0));
        chk("bp_in_ready_after_hs", 128'(tb_in_ready[0]), 128'(1));
        @(posedge clk);
        #1;
        tb_in_valid[0] = 1'b0;
        chk("bp_accept_next", 128'(tb_busy[0]), 128'(1));
        exp_q.push_back(ref_enc(0, 128'h0123456789abcdef0123456789abcdef));
        wait_out(0, lat);
        chk("bp2_latency", 128'(lat), 128'(10));
        recv(0, "bp2_ct");

        // Reset while running round 5 discards the block.
        send(0, 128'h00000000000000000000000000000001, ref_enc(0, 128'h00000000000000000000000000000001));
        repeat (4) @(posedge clk);
        #1;
        chk("run_rk_idx5", 128'(tb_rk_idx[0]), 128'(5));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        void'(exp_q.pop_back());
        chk("mid_rst_in_ready", 128'(tb_in_ready[0]), 128'(1));
        chk("mid_rst_busy", 128'(tb_busy[0]), 128'(0));
        chk("mid_rst_rk_idx", 128'(tb_rk_idx[0]), 128'(0));
        errs = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (tb_out_valid[0] !== 1'b0) errs++;
        end
        chk("mid_rst_no_out", 128'(errs), 128'(0));
        @(posedge clk);
        #1;
        send(0, 128'h00000000000000000000000000000001, ref_enc(0, 128'h00000000000000000000000000000001));
        wait_out(0, lat);
        chk("after_rst_latency", 128'(lat), 128'(10));
        recv(0, "after_rst_ct");

        // Stream of random blocks with random output back-pressure.
        fork
            begin : drv
                logic [127:0] pt;
                for (int i = 0; i < 8; i++) begin
                    pt = {$urandom, $urandom, $urandom, $urandom};
                    send(0, pt, ref_enc(0, pt));
                end
            end
            begin : mon
                int got = 0;
                int cyc = 0;
                while (got < 8 && cyc < 3000) begin
                    @(posedge clk);
                    #1;
                    tb_out_ready[0] = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    cyc++;
                    if (tb_out_valid[0] && tb_out_ready[0]) begin
                        pop_chk($sformatf("stream_ct%0d", got), tb_out_data[0]);
                        got++;
                    end
                end
                chk("stream_count", 128'(got), 128'(8));
                @(posedge clk);
                #1;
                tb_out_ready[0] = 1'b0;
            end
        join

        chk("sb_drained", 128'(exp_q.size()), 128'(0));
        chk("rk_idx_range", 128'(rk_viol), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
